// File: rtl/wave_display_ctrl.sv
// Waveform overlay for a VGA scan: reads one 8-bit sample per column pair from the
// display-owned half of the sample RAM and lights the rows joining adjacent samples.
module wave_display_ctrl #(
   parameter logic [23:0] WAVE_RGB = 24'hFFFFFF,
   parameter logic [9:0]  Y_TOP    = 10'd128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [9:0]  y,
   input  logic        valid,
   input  logic        read_index,
   input  logic [7:0]  read_value,
   output logic [8:0]  read_address,
   output logic        valid_pixel,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        wave_display_idle
);

   localparam logic [10:0] Y_LO = {1'b0, Y_TOP};
   localparam logic [10:0] Y_HI = Y_LO + 11'd256;

   logic [10:0] y_ext;
   logic        in_rows;
   logic        in_window;
   logic        frame_start;
   logic [7:0]  yr;

   logic        latched_index;
   logic        s1_win;
   logic [7:0]  s1_yr;
   logic [7:0]  s1_idx;
   logic [7:0]  last_idx;
   logic [7:0]  prev_h;
   logic [7:0]  cur_h;

   logic [7:0]  h;
   logic [7:0]  eff_prev;
   logic        lit;

   assign y_ext       = {1'b0, y};
   assign in_rows     = (y_ext >= Y_LO) && (y_ext < Y_HI);
   assign in_window   = valid && in_rows && (x < 11'd512);
   assign frame_start = valid && (x == 11'd0) && (y == 10'd0);
   // Row offset wraps modulo 256, so only the low byte of Y_TOP matters here.
   assign yr          = y[7:0] - Y_TOP[7:0];

   assign read_address = {latched_index, x[8:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         latched_index <= 1'b0;
      end else if (frame_start) begin
         latched_index <= read_index;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_win <= 1'b0;
         s1_yr  <= 8'd0;
         s1_idx <= 8'd0;
      end else begin
         s1_win <= in_window;
         s1_yr  <= yr;
         s1_idx <= x[8:1];
      end
   end

   // The line for a sample runs from the previous visible sample's height to its own;
   // sample 0 starts a fresh trace so it never joins the tail of the last row.
   always_comb begin
      h        = 8'd255 - read_value;
      eff_prev = prev_h;
      if (s1_idx == 8'd0) begin
         eff_prev = h;
      end else if (s1_idx != last_idx) begin
         eff_prev = cur_h;
      end
      lit = s1_win &&
            (((s1_yr >= eff_prev) && (s1_yr <= h)) ||
             ((s1_yr >= h) && (s1_yr <= eff_prev)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_h   <= 8'd0;
         cur_h    <= 8'd0;
         last_idx <= 8'd0;
      end else if (s1_win) begin
         prev_h   <= eff_prev;
         cur_h    <= h;
         last_idx <= s1_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_pixel <= 1'b0;
         r           <= 8'd0;
         g           <= 8'd0;
         b           <= 8'd0;
      end else if (lit) begin
         valid_pixel <= 1'b1;
         r           <= WAVE_RGB[23:16];
         g           <= WAVE_RGB[15:8];
         b           <= WAVE_RGB[7:0];
      end else begin
         valid_pixel <= 1'b0;
         r           <= 8'd0;
         g           <= 8'd0;
         b           <= 8'd0;
      end
   end

   // Idle ignores valid so capture can swap banks during blanking rows as well.
   always_ff @(posedge clk) begin
      if (reset) begin
         wave_display_idle <= 1'b0;
      end else begin
         wave_display_idle <= !in_rows;
      end
   end

endmodule

// File: doc/wave_display_ctrl.md
WAVE_DISPLAY_CTRL -- requirements
Module: wave_display_ctrl

Interface
REQ-001 Parameter WAVE_RGB, default 24'hFFFFFF, colour of lit waveform pixels as {r,g,b}.
REQ-002 Parameter Y_TOP, default 10'd128, first display row of the 256-row waveform window.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 x  input  11  VGA pixel column of the current cycle.
REQ-006 y  input  10  VGA pixel row of the current cycle.
REQ-007 valid  input  1  VGA active-video qualifier for x/y.
REQ-008 read_index  input  1  sample-RAM half currently owned by the display (from capture block).
REQ-009 read_value  input  8  sample-RAM read data; one-cycle read latency, offset-binary (128 = zero).
REQ-010 read_address  output  9  sample-RAM read address {bank, sample}.
REQ-011 valid_pixel  output  1  high when r/g/b carry a waveform pixel.
REQ-012 r, g, b  output  8 each  pixel colour.
REQ-013 wave_display_idle  output  1  high when display is outside the waveform window, so capture may swap banks.

Function
REQ-014 Window: x in 0..511 and y in Y_TOP..Y_TOP+255 with valid=1; row offset yr = y - Y_TOP (8 bits).
REQ-015 Bank latch: latched_index SHALL load read_index on the cycle where valid=1, x=0, y=0; held otherwise.
REQ-016 read_address SHALL be combinational {latched_index, x[8:1]}; each sample spans 2 columns.
REQ-017 Pipeline stage 1 (cycle t+1): register x, yr, in-window flag, and x[8:1]; read_value arrives aligned with this stage.
REQ-018 Displayed height h = 8'd255 - read_value (bit 7 up = top of window), 8-bit, no overflow.
REQ-019 prev_h register: on stage-1 cycles where the stage-1 sample index differs from the previous stage-1 sample index, prev_h SHALL load the previous cur_h; cur_h SHALL load h every in-window stage-1 cycle.
REQ-020 Column 0 rule: when stage-1 sample index = 0, prev_h SHALL equal h (no line joined from the previous row's sample 255).
REQ-021 Pixel lit when stage-1 in-window and yr lies between prev_h and cur_h inclusive (either order); equal values light exactly one row.
REQ-022 Stage 2 (cycle t+2): valid_pixel, r, g, b registered; lit -> valid_pixel=1, {r,g,b}=WAVE_RGB; else valid_pixel=0, r=g=b=0.
REQ-023 Total latency x/y -> pixel output SHALL be exactly 2 cycles, every cycle, no stalls.
REQ-024 wave_display_idle registered, 1-cycle latency: 1 when y >= Y_TOP+256 or y < Y_TOP, else 0; independent of valid.
REQ-025 read_index changing mid-frame SHALL NOT affect read_address until the next frame-start latch.
REQ-026 Inputs with valid=0 SHALL produce valid_pixel=0 two cycles later, and SHALL NOT update prev_h/cur_h.
REQ-027 x >= 512 SHALL be treated as out-of-window; read_address still driven per REQ-016 (don't-care data).

Reset
REQ-028 While reset=1 at a clock edge: latched_index=0, prev_h=cur_h=0, pipeline flags=0, valid_pixel=0, r=g=b=0, wave_display_idle=0.
REQ-029 Reset mid-frame SHALL discard in-flight pixels; normal output resumes 2 cycles after the first non-reset cycle, with bank 0 until the next frame start.
REQ-030 read_address SHALL show {0, x[8:1]} during and after reset until the next latch.

Verification
REQ-031 RAM model all samples = 128, sweep frame -> exactly one lit row per window column at yr=127, valid_pixel 2 cycles after x/y.
REQ-032 Sample 0 = 0, sample 1 = 255 -> columns 2-3 light yr 0..255 inclusive (full vertical line); columns 0-1 light only yr=255.
REQ-033 read_index toggles 0->1 at y=200 -> read_address[8] stays 0 rest of frame, becomes 1 from x=0,y=0 of next frame.
REQ-034 y=Y_TOP+256 -> wave_display_idle=1 next cycle; y=Y_TOP -> idle=0 next cycle; valid=0 rows behave identically.
REQ-035 Assert reset at x=300 inside window for 3 cycles -> valid_pixel=0 through reset and 2 cycles after; latched_index=0.
REQ-036 valid=0 for x in 100..101 mid-row -> no pixels there, prev_h unchanged, column 102 joins sample 49 to sample 51.
